// File: rtl/mem16_arbiter.sv
// 16x4 register memory shared by two round-robin ports,
// with a background greatest-value scan engine.
module mem16_arbiter #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [3:0]       adrs0,
  input  logic [3:0]       adrs1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             dsrc,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_done,
  output logic [WIDTH-1:0] grtst,
  output logic [3:0]       grtst_adrs
);

  // {addr15 .. addr0}
  localparam logic [63:0] INIT = {
    4'd0, 4'd1, 4'd15, 4'd2,
    4'd14, 4'd9, 4'd7, 4'd1,
    4'd0, 4'd5, 4'd12, 4'd8,
    4'd7, 4'd9, 4'd3, 4'd1
  };

  typedef enum logic {
    IDLE,
    SCAN
  } scan_st_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             last;
  scan_st_t         state;
  logic [3:0]       idx;
  logic [WIDTH-1:0] run_max;
  logic [3:0]       run_adrs;
  logic [WIDTH-1:0] cur;
  logic             ge;
  logic             step;

  // last=1 means port 1 won most recently
  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);

  assign cur  = mem[idx];
  assign ge   = (cur >= run_max);
  assign step = (state == SCAN) & ~gnt0 & ~gnt1;

  // port accesses: memory writes, registered reads, rr pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= WIDTH'(INIT[i*4 +: 4]);
      last   <= 1'b1;
      dout   <= '0;
      dvalid <= 1'b0;
      dsrc   <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      if (gnt0) begin
        last <= 1'b0;
        if (we0) begin
          mem[adrs0] <= din0;
        end else begin
          dout   <= mem[adrs0];
          dvalid <= 1'b1;
          dsrc   <= 1'b0;
        end
      end else if (gnt1) begin
        last <= 1'b1;
        if (we1) begin
          mem[adrs1] <= din1;
        end else begin
          dout   <= mem[adrs1];
          dvalid <= 1'b1;
          dsrc   <= 1'b1;
        end
      end
    end
  end

  // scan FSM: one step per cycle with no port grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      run_max    <= '0;
      run_adrs   <= '0;
      scan_busy  <= 1'b0;
      scan_done  <= 1'b0;
      grtst      <= '0;
      grtst_adrs <= '0;
    end else begin
      scan_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (scan_start) begin
            state     <= SCAN;
            idx       <= '0;
            run_max   <= '0;
            run_adrs  <= '0;
            scan_busy <= 1'b1;
          end
        end
        SCAN: begin
          if (step) begin
            if (idx == 4'd15) begin
              grtst      <= ge ? cur : run_max;
              grtst_adrs <= ge ? idx : run_adrs;
              scan_done  <= 1'b1;
              scan_busy  <= 1'b0;
              state      <= IDLE;
            end else begin
              if (ge) begin
                run_max  <= cur;
                run_adrs <= idx;
              end
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
